// File: rtl/perfmon_snapshot_master_if.sv
// perfmon_snapshot_master_if: MMIO initiator bus and snapshot FIFO read port.
// master = snapshot engine side, slave = bus responder / FIFO consumer side.
interface perfmon_snapshot_master_if;
  logic        bus_req;
  logic        bus_gnt;
  logic        mmio_enable;
  logic [6:0]  mmio_addr;
  logic [31:0] mmio_wdata;
  logic [31:0] mmio_rdata;
  logic [31:0] fifo_rdata;
  logic        fifo_valid;
  logic        fifo_ready;

  modport master (
    output bus_req,
    output mmio_enable,
    output mmio_addr,
    output mmio_wdata,
    output fifo_rdata,
    output fifo_valid,
    input  bus_gnt,
    input  mmio_rdata,
    input  fifo_ready
  );

  modport slave (
    input  bus_req,
    input  mmio_enable,
    input  mmio_addr,
    input  mmio_wdata,
    input  fifo_rdata,
    input  fifo_valid,
    output bus_gnt,
    output mmio_rdata,
    output fifo_ready
  );
endinterface

// File: rtl/perfmon_snapshot_master.sv
// perfmon_snapshot_master: tear-free perfmon snapshots over MMIO into a FIFO.
// Define PERFMON_SNAP_PET_EN to add a watchdog pet write (0x30) per frame.
module perfmon_snapshot_master #(
  parameter int FIFO_DEPTH = 16,
  parameter int PERIOD_W   = 32
) (
  input  logic                soc_clk,
  input  logic                rst,
  input  logic                snap_req,
  input  logic [PERIOD_W-1:0] period,
  perfmon_snapshot_master_if.master bus,
  output logic                busy,
  output logic [7:0]          drop_count
);

  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int CW    = AW + 1;
  localparam int FRAME = 8;

`ifdef PERFMON_SNAP_PET_EN
  localparam logic PET_BIT = 1'b1;
`else
  localparam logic PET_BIT = 1'b0;
`endif

  typedef enum logic [3:0] {
    S_IDLE,
    S_REQ,
    S_SOC_HI,
    S_SOC_LO,
    S_SOC_HI2,
    S_SOC_LO2,
    S_CORE_HI,
    S_CORE_LO,
    S_CORE_HI2,
    S_CORE_LO2,
    S_MISS,
    S_RET,
    S_STAT,
`ifdef PERFMON_SNAP_PET_EN
    S_PET,
`endif
    S_DRAIN
  } state_t;

  state_t state;
  state_t state_d;
  state_t acc_nxt;

  logic                acc;
  logic [6:0]          acc_addr;
  logic                gnt_acc;
  logic                soc_tear;
  logic                core_tear;

  logic [PERIOD_W-1:0] tmr;
  logic                tick;
  logic                fire;
  logic                pending;
  logic                room;
  logic                drop_flag;
  logic [15:0]         seq;
  logic [2:0]          widx;
  logic                last;

  logic [31:0]         soc_hi;
  logic [31:0]         soc_lo;
  logic [31:0]         core_hi;
  logic [31:0]         core_lo;
  logic [31:0]         miss;
  logic [31:0]         ret;
  logic [31:0]         stat;
  logic                tear_flag;

  logic [31:0]         hdr;
  logic [31:0]         word;
  logic                push;
  logic                pop;
  logic [31:0]         mem [FIFO_DEPTH];
  logic [AW-1:0]       wp;
  logic [AW-1:0]       rp;
  logic [CW-1:0]       cnt;

  // drop_flag marks a frame lost since the last one; no port carries it
  logic                unused_drop;
  assign unused_drop = drop_flag;

  assign tick = (period != '0) &&
                (tmr == period - PERIOD_W'(1));
  assign fire = snap_req | tick | pending;
  assign room = cnt <= CW'(FIFO_DEPTH - FRAME);
  assign last = (state == S_DRAIN) && (widx == 3'd7);

  assign soc_tear  = bus.mmio_rdata != soc_hi;
  assign core_tear = bus.mmio_rdata != core_hi;

  always_comb begin
    acc      = 1'b1;
    acc_addr = '0;
    acc_nxt  = state;
    unique case (state)
      S_SOC_HI: begin
        acc_addr = 7'h10;
        acc_nxt  = S_SOC_LO;
      end
      S_SOC_LO: begin
        acc_addr = 7'h14;
        acc_nxt  = S_SOC_HI2;
      end
      S_SOC_HI2: begin
        acc_addr = 7'h10;
        acc_nxt  = soc_tear ? S_SOC_LO2 : S_CORE_HI;
      end
      S_SOC_LO2: begin
        acc_addr = 7'h14;
        acc_nxt  = S_CORE_HI;
      end
      S_CORE_HI: begin
        acc_addr = 7'h18;
        acc_nxt  = S_CORE_LO;
      end
      S_CORE_LO: begin
        acc_addr = 7'h1C;
        acc_nxt  = S_CORE_HI2;
      end
      S_CORE_HI2: begin
        acc_addr = 7'h18;
        acc_nxt  = core_tear ? S_CORE_LO2 : S_MISS;
      end
      S_CORE_LO2: begin
        acc_addr = 7'h1C;
        acc_nxt  = S_MISS;
      end
      S_MISS: begin
        acc_addr = 7'h28;
        acc_nxt  = S_RET;
      end
      S_RET: begin
        acc_addr = 7'h2C;
        acc_nxt  = S_STAT;
      end
      S_STAT: begin
        acc_addr = 7'h0C;
`ifdef PERFMON_SNAP_PET_EN
        acc_nxt  = S_PET;
`else
        acc_nxt  = S_DRAIN;
`endif
      end
`ifdef PERFMON_SNAP_PET_EN
      S_PET: begin
        acc_addr = 7'h30;
        acc_nxt  = S_DRAIN;
      end
`endif
      default: acc = 1'b0;
    endcase
  end

  assign gnt_acc = acc & bus.bus_gnt;

  always_comb begin
    state_d = state;
    if (acc) begin
      if (bus.bus_gnt) state_d = acc_nxt;
    end else begin
      unique case (state)
        S_IDLE:  if (fire && room) state_d = S_REQ;
        S_REQ:   if (bus.bus_gnt) state_d = S_SOC_HI;
        S_DRAIN: if (last) state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign bus.bus_req     = acc | (state == S_REQ);
  assign bus.mmio_enable = gnt_acc;
  assign bus.mmio_addr   = acc_addr;
  assign bus.mmio_wdata  = '0;
  assign busy            = state != S_IDLE;

  always_ff @(posedge soc_clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      tmr        <= '0;
      pending    <= 1'b0;
      drop_count <= '0;
      drop_flag  <= 1'b0;
      seq        <= '0;
      widx       <= '0;
    end else begin
      state <= state_d;
      if (period == '0 || tick) tmr <= '0;
      else tmr <= tmr + PERIOD_W'(1);
      // triggers arriving mid-frame collapse into one retry
      if (state == S_IDLE) pending <= 1'b0;
      else if (snap_req || tick) pending <= 1'b1;
      if (state == S_IDLE && fire && !room) begin
        drop_flag <= 1'b1;
        if (drop_count != 8'hFF)
          drop_count <= drop_count + 8'd1;
      end
      if (state == S_DRAIN) widx <= widx + 3'd1;
      if (last) begin
        seq       <= seq + 16'd1;
        drop_flag <= 1'b0;
        widx      <= '0;
      end
    end
  end

  always_ff @(posedge soc_clk or posedge rst) begin
    if (rst) begin
      soc_hi    <= '0;
      soc_lo    <= '0;
      core_hi   <= '0;
      core_lo   <= '0;
      miss      <= '0;
      ret       <= '0;
      stat      <= '0;
      tear_flag <= 1'b0;
    end else if (last) begin
      tear_flag <= 1'b0;
    end else if (gnt_acc) begin
      unique case (state)
        S_SOC_HI:  soc_hi <= bus.mmio_rdata;
        S_SOC_LO,
        S_SOC_LO2: soc_lo <= bus.mmio_rdata;
        S_SOC_HI2: if (soc_tear) begin
          soc_hi    <= bus.mmio_rdata;
          tear_flag <= 1'b1;
        end
        S_CORE_HI: core_hi <= bus.mmio_rdata;
        S_CORE_LO,
        S_CORE_LO2: core_lo <= bus.mmio_rdata;
        S_CORE_HI2: if (core_tear) begin
          core_hi   <= bus.mmio_rdata;
          tear_flag <= 1'b1;
        end
        S_MISS: miss <= bus.mmio_rdata;
        S_RET:  ret  <= bus.mmio_rdata;
        S_STAT: stat <= bus.mmio_rdata;
        default: ;
      endcase
    end
  end

  assign hdr = {seq, drop_count, 5'd0,
                1'b0, PET_BIT, tear_flag};

  always_comb begin
    word = '0;
    unique case (widx)
      3'd0: word = hdr;
      3'd1: word = soc_hi;
      3'd2: word = soc_lo;
      3'd3: word = core_hi;
      3'd4: word = core_lo;
      3'd5: word = miss;
      3'd6: word = ret;
      3'd7: word = stat;
      default: word = '0;
    endcase
  end

  // IDLE only launches with a full frame of space, so pushes never stall
  assign push = state == S_DRAIN;
  assign pop  = bus.fifo_valid & bus.fifo_ready;

  always_ff @(posedge soc_clk) begin
    if (push) mem[wp] <= word;
  end

  always_ff @(posedge soc_clk or posedge rst) begin
    if (rst) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (push) wp <= wp + AW'(1);
      if (pop)  rp <= rp + AW'(1);
      unique case ({push, pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  assign bus.fifo_valid = cnt != '0;
  assign bus.fifo_rdata = mem[rp];

endmodule

// File: tb/tb_perfmon_snapshot_master.sv
// tb_perfmon_snapshot_master: directed checks of the snapshot engine.
// Responder model serves counter reads; frames are popped and compared.
module tb_perfmon_snapshot_master;

`ifdef PERFMON_SNAP_PET_EN
  localparam int PET = 1;
`else
  localparam int PET = 0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        snap_req = 1'b0;
  logic [31:0] period = '0;
  logic        busy;
  logic [7:0]  drop_count;

  perfmon_snapshot_master_if bus_if ();

  perfmon_snapshot_master #(
    .FIFO_DEPTH(16),
    .PERIOD_W(32)
  ) dut (
    .soc_clk(clk),
    .rst(rst),
    .snap_req(snap_req),
    .period(period),
    .bus(bus_if),
    .busy(busy),
    .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  int n_tot = 0;
  int n_bad = 0;
  int cyc = 0;
  int t0;

  // responder contents
  logic [31:0] r_shi_a, r_shi_b, r_slo_a, r_slo_b;
  logic [31:0] r_chi, r_clo, r_miss, r_ret, r_stat;
  logic [31:0] rdata;

  // expected frame payload
  logic [31:0] e_shi, e_slo, e_chi, e_clo;
  logic [31:0] e_miss, e_ret, e_stat;

  // monitor state (owned by the monitor process only)
  logic [6:0] alog [16];
  int n_log = 0;
  int hi_rd = 0;
  int lo_rd = 0;
  int n_pet = 0;
  int a30 = 0;
  logic busy_q = 1'b0;

  logic [6:0] exp_q [$];

  always_comb begin
    rdata = 32'hDEAD_BEEF;
    case (bus_if.mmio_addr)
      7'h10: rdata = (hi_rd == 0) ? r_shi_a : r_shi_b;
      7'h14: rdata = (lo_rd == 0) ? r_slo_a : r_slo_b;
      7'h18: rdata = r_chi;
      7'h1C: rdata = r_clo;
      7'h28: rdata = r_miss;
      7'h2C: rdata = r_ret;
      7'h0C: rdata = r_stat;
      default: rdata = 32'hDEAD_BEEF;
    endcase
  end
  assign bus_if.mmio_rdata = rdata;

  always @(posedge clk) begin
    busy_q <= busy;
    if (bus_if.mmio_addr == 7'h30) a30 <= a30 + 1;
    if (busy && !busy_q) begin
      n_log <= 0;
      hi_rd <= 0;
      lo_rd <= 0;
      n_pet <= 0;
    end else if (bus_if.mmio_enable) begin
      if (n_log < 16) alog[n_log] <= bus_if.mmio_addr;
      n_log <= n_log + 1;
      if (bus_if.mmio_addr == 7'h10) hi_rd <= hi_rd + 1;
      if (bus_if.mmio_addr == 7'h14) lo_rd <= lo_rd + 1;
      if (bus_if.mmio_addr == 7'h30) n_pet <= n_pet + 1;
    end
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic snap();
    snap_req = 1'b1;
    tick();
    snap_req = 1'b0;
    t0 = cyc;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy && n < 500) begin
      tick();
      n++;
    end
    chk(tag, {31'd0, busy}, 32'd0);
  endtask

  task automatic set_plain(input logic [31:0] shi,
                           input logic [31:0] slo);
    r_shi_a = shi; r_shi_b = shi;
    r_slo_a = slo; r_slo_b = slo;
    e_shi = shi; e_slo = slo;
    e_chi = r_chi; e_clo = r_clo;
    e_miss = r_miss; e_ret = r_ret; e_stat = r_stat;
  endtask

  task automatic build_log(input bit tear);
    exp_q.delete();
    exp_q.push_back(7'h10);
    exp_q.push_back(7'h14);
    exp_q.push_back(7'h10);
    if (tear) exp_q.push_back(7'h14);
    exp_q.push_back(7'h18);
    exp_q.push_back(7'h1C);
    exp_q.push_back(7'h18);
    exp_q.push_back(7'h28);
    exp_q.push_back(7'h2C);
    exp_q.push_back(7'h0C);
    if (PET == 1) exp_q.push_back(7'h30);
  endtask

  task automatic chk_log(input string tag);
    chk({tag, "_n"}, n_log, exp_q.size());
    for (int i = 0; i < exp_q.size() && i < 16; i++)
      chk($sformatf("%s_a%0d", tag, i), {25'd0, alog[i]},
          {25'd0, exp_q[i]});
  endtask

  task automatic pop_frame(input string tag, input logic [31:0] hdr);
    logic [31:0] e [8];
    e[0] = hdr;    e[1] = e_shi; e[2] = e_slo; e[3] = e_chi;
    e[4] = e_clo;  e[5] = e_miss; e[6] = e_ret; e[7] = e_stat;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("%s_v%0d", tag, i), {31'd0, bus_if.fifo_valid}, 32'd1);
      chk($sformatf("%s_w%0d", tag, i), bus_if.fifo_rdata, e[i]);
      bus_if.fifo_ready = 1'b1;
      tick();
      bus_if.fifo_ready = 1'b0;
    end
  endtask

  function automatic logic [31:0] mk_hdr(input int sq, input int dc,
                                         input bit tear);
    return {sq[15:0], dc[7:0], 6'd0, PET[0], tear};
  endfunction

  initial begin
    int n;
    int rise1;
    bus_if.bus_gnt = 1'b1;
    bus_if.fifo_ready = 1'b0;
    r_chi = 32'h0; r_clo = 32'h5;
    r_miss = 32'd7; r_ret = 32'd9; r_stat = 32'hA5A5_0001;
    set_plain(32'h1, 32'h10);
    tick(); tick();
    rst = 1'b0;
    tick();

    // reset state
    chk("rst_req", {31'd0, bus_if.bus_req}, 0);
    chk("rst_en", {31'd0, bus_if.mmio_enable}, 0);
    chk("rst_addr", {25'd0, bus_if.mmio_addr}, 0);
    chk("rst_fv", {31'd0, bus_if.fifo_valid}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_drop", {24'd0, drop_count}, 0);

    // basic frame with cycle-accurate timing
    snap();
    chk("b_busy1", {31'd0, busy}, 1);
    chk("b_req1", {31'd0, bus_if.bus_req}, 1);
    chk("b_en1", {31'd0, bus_if.mmio_enable}, 0);
    for (int i = 1; i <= 18 + PET; i++) begin
      tick();
      if (i == 1) chk("b_addr2", {25'd0, bus_if.mmio_addr}, 32'h10);
      if (i == 10 + PET)
        chk("b_fv11", {31'd0, bus_if.fifo_valid}, 0);
      if (i == 11 + PET) begin
        chk("b_fv12", {31'd0, bus_if.fifo_valid}, 1);
        chk("b_hdr12", bus_if.fifo_rdata, mk_hdr(0, 0, 0));
        chk("b_req12", {31'd0, bus_if.bus_req}, 0);
      end
      if (i == 17 + PET) chk("b_busy18", {31'd0, busy}, 1);
      if (i == 18 + PET) chk("b_busy19", {31'd0, busy}, 0);
    end
    wait_idle("b_idle");
    build_log(0);
    chk_log("b_log");
    chk("b_pet", n_pet, PET);
    pop_frame("b", mk_hdr(0, 0, 0));
    chk("b_empty", {31'd0, bus_if.fifo_valid}, 0);

    // torn SOC read: HI 0 -> 1 across LO wrap
    r_shi_a = 32'h0; r_shi_b = 32'h1;
    r_slo_a = 32'hFFFF_FFFF; r_slo_b = 32'h0000_0002;
    e_shi = 32'h1; e_slo = 32'h2;
    snap();
    wait_idle("t_idle");
    chk("t_dur", cyc - t0, 19 + PET);
    build_log(1);
    chk_log("t_log");
    pop_frame("t", mk_hdr(1, 0, 1));

    // grant low for 3 cycles in CORE_LO
    r_clo = 32'h0000_1234;
    set_plain(32'h2, 32'h20);
    snap();
    n = 0;
    while (bus_if.mmio_addr != 7'h1C && n < 50) begin
      tick();
      n++;
    end
    chk("s_at_clo", {25'd0, bus_if.mmio_addr}, 32'h1C);
    bus_if.bus_gnt = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("s_en%0d", i), {31'd0, bus_if.mmio_enable}, 0);
      chk($sformatf("s_addr%0d", i), {25'd0, bus_if.mmio_addr}, 32'h1C);
      chk($sformatf("s_req%0d", i), {31'd0, bus_if.bus_req}, 1);
      tick();
    end
    bus_if.bus_gnt = 1'b1;
    wait_idle("s_idle");
    chk("s_dur", cyc - t0, 21 + PET);
    build_log(0);
    chk_log("s_log");
    pop_frame("s", mk_hdr(2, 0, 0));

    // overflow: two frames fit, the third is dropped
    set_plain(32'h3, 32'h30);
    snap(); wait_idle("o_idle1");
    snap(); wait_idle("o_idle2");
    snap();
    tick();
    chk("o_busy", {31'd0, busy}, 0);
    chk("o_drop", {24'd0, drop_count}, 1);
    pop_frame("o1", mk_hdr(3, 0, 0));
    pop_frame("o2", mk_hdr(4, 0, 0));
    chk("o_empty", {31'd0, bus_if.fifo_valid}, 0);
    snap(); wait_idle("o_idle3");
    pop_frame("o3", mk_hdr(5, 1, 0));

    // reset mid-frame with a frame still queued
    snap(); wait_idle("r_idle");
    snap();
    n = 0;
    while (bus_if.mmio_addr != 7'h1C && n < 50) begin
      tick();
      n++;
    end
    chk("r_at_clo", {25'd0, bus_if.mmio_addr}, 32'h1C);
    rst = 1'b1;
    #1;
    chk("r_req", {31'd0, bus_if.bus_req}, 0);
    chk("r_busy", {31'd0, busy}, 0);
    chk("r_fv", {31'd0, bus_if.fifo_valid}, 0);
    chk("r_drop", {24'd0, drop_count}, 0);
    tick();
    rst = 1'b0;
    tick();
    snap(); wait_idle("r_idle2");
    pop_frame("r", mk_hdr(0, 0, 0));

    // periodic trigger every 100 cycles
    period = 32'd100;
    t0 = cyc;
    n = 0;
    while (!busy && n < 300) begin
      tick();
      n++;
    end
    chk("p_first", cyc - t0, 100);
    rise1 = cyc;
    wait_idle("p_idle1");
    chk("p_pet1", n_pet, PET);
    pop_frame("p1", mk_hdr(1, 0, 0));
    n = 0;
    while (!busy && n < 300) begin
      tick();
      n++;
    end
    chk("p_gap", cyc - rise1, 100);
    period = 32'd0;
    wait_idle("p_idle2");
    chk("p_pet2", n_pet, PET);
    pop_frame("p2", mk_hdr(2, 0, 0));
    n = 0;
    repeat (150) begin
      tick();
      if (busy) n++;
    end
    chk("p_off", n, 0);
    chk("a30_seen", {31'd0, a30 != 0}, PET);

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule

// File: doc/perfmon_snapshot_master.md
# perfmon_snapshot_master

MMIO bus initiator that captures coherent snapshots of the performance-monitor counter block and queues them for software or debug logic. On a software pulse or an internal periodic timer it requests the shared MMIO bus, reads the 64-bit SOC and core cycle counters tear-free, then reads the I-miss count, retired count and status. It writes each snapshot as an 8-word frame into an internal FIFO with a valid/ready read port.

## Interface
- FIFO_DEPTH, 16: snapshot FIFO depth in 32-bit words; power of two, ≥ 8.
- PERIOD_W, 32: width of the periodic-trigger interval.

- soc_clk  in  1  sole clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- snap_req  in  1  one-cycle snapshot trigger.
- period  in  PERIOD_W  periodic interval in soc_clk cycles; 0 disables the periodic trigger.
- bus_req  out  1  MMIO bus request.
- bus_gnt  in  1  MMIO bus grant, may drop in any cycle.
- mmio_enable  out  1  perfmon select; equals bus_gnt in access states, else 0.
- mmio_addr  out  7  perfmon register address.
- mmio_wdata  out  32  write data; always 0.
- mmio_rdata  in  32  combinational read data, valid in the same cycle as mmio_enable/mmio_addr.
- fifo_rdata  out  32  head FIFO word.
- fifo_valid  out  1  FIFO not empty.
- fifo_ready  in  1  pop head when fifo_valid & fifo_ready.
- busy  out  1  high from REQ through the last DRAIN cycle.
- drop_count  out  8  dropped frames; saturates at 255.

## Operation
- **Triggers:** snap_req, or period timer expiry.
  - Timer counts every cycle. When period≠0 and count==period−1, it fires and clears to 0. period==0 holds count at 0.
  - A trigger while not IDLE sets a single pending flag. Further triggers merge into it.
- **IDLE:** on trigger or pending, check FIFO free space.
  - free ≥ 8: clear pending, go to REQ.
  - free < 8: drop_count++ (saturating), set drop_flag, stay IDLE.
- **REQ:** assert bus_req; advance to the first access when bus_gnt=1.
- **Access states and addresses:**
  - SOC_HI 0x10, SOC_LO 0x14, SOC_HI2 0x10
  - SOC_LO2 0x14, only if the HI2 read ≠ the HI read
  - CORE_HI 0x18, CORE_LO 0x1C, CORE_HI2 0x18
  - CORE_LO2 0x1C, conditional on the same rule
  - MISS 0x28, RET 0x2C, STAT 0x0C
  - PET 0x30, write, under the configuration macro
- **Access rules:**
  - bus_req stays 1 through all access states.
  - mmio_addr holds the state address.
  - rdata is captured into a staging register, and the state advances, only in cycles with bus_gnt=1. With bus_gnt=0 the state and address hold.
- **Tear resolution:** on a HI mismatch, the staged HI becomes the HI2 value, LO is re-read, and tear_flag is set.
- **DRAIN:** bus_req=0. Push one word per cycle, in this order:
  - header: [31:16] frame sequence number, [15:8] drop_count, [2] 0, [1] pet issued, [0] tear_flag
  - soc hi, soc lo, core hi, core lo, miss, retired, status
- **End of frame:** sequence number increments (16-bit wrap); tear_flag and drop_flag clear; return to IDLE.
- **FIFO:**
  - First-word-fall-through. Push and pop may occur in the same cycle.
  - Reserved space cannot shrink during a frame, so a push is never lost.
- **Reset (any time):**
  - All outputs 0: bus_req, mmio_enable, mmio_addr, fifo_valid, busy, drop_count.
  - FIFO empty; sequence number, pending flag, timer and state cleared; state IDLE.

## Timing
- Reference case: snap_req sampled at edge 0, bus_gnt held 1, no tear, macro off.
  - Cycle 1: REQ.
  - Cycles 2–10: accesses.
  - Cycles 11–18: DRAIN.
  - fifo_valid=1 with header on fifo_rdata from cycle 12.
  - busy falls after cycle 18.
- Each tear re-read adds 1 cycle; PET adds 1 cycle.
- Each grant-low cycle adds 1 cycle.
- Read data is sampled in the same cycle it is addressed. No wait states.

## Configuration
- PERFMON_SNAP_PET_EN defined: after STAT, the PET state issues one write access to 0x30, which clears watchdog_panic. Header bit1=1.
- Not defined: no PET state, address 0x30 is never driven, header bit1=0.

## Test plan
- **Reset:** assert rst mid-frame (CORE_LO) → bus_req=0 and busy=0 immediately, FIFO empty, drop_count=0; the next snapshot has header seq=0.
- **Basic frame:** snap_req, gnt=1, responder soc=0x1_00000010, core=0x5, miss=7, retired=9 → 8 words pop in order; header=0x00000000; words match; busy falls after cycle 18.
- **Tear:** responder returns soc HI=0, LO=0xFFFFFFFF, HI2=1 → SOC_LO2 is issued; frame holds soc hi=1, lo=re-read value; header bit0=1.
- **Grant stall:** drop bus_gnt for 3 cycles during CORE_LO → mmio_enable=0 and mmio_addr held at 0x1C; frame is correct and completes 3 cycles late.
- **Overflow:** fifo_ready=0, FIFO_DEPTH=16, three snap_reqs → two frames stored, third dropped, drop_count=1; after draining, the next header shows [15:8]=1 and seq=2.
- **Periodic and pet:** period=100, macro on → snapshots every 100 cycles; each frame has exactly one write to 0x30; header bit1=1.
